// File: rtl/uart_rx_frame_capture.sv
// 8E1 UART receiver with 16x oversampling, selectable baud, error flags and a
// 4-byte history of good bytes (newest in the low byte) for a display driver.
module uart_rx_frame_capture #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BUF_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  baud_select,
  input  logic        Rx_EN,
  input  logic        RxD,
  output logic [7:0]  Rx_DATA,
  output logic        Rx_VALID,
  output logic        Rx_PERROR,
  output logic        Rx_FERROR,
  output logic [31:0] buf_word,
  output logic [2:0]  byte_count
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Rounded divisor for a 16x tick; folds to a constant per baud code.
  function automatic logic [31:0] div_of(input int unsigned baud);
    return 32'((CLK_HZ + 8 * baud) / (16 * baud));
  endfunction

  state_t      state, state_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic [2:0]  baud_lat;
  logic [31:0] div_val, div_cnt;
  logic [3:0]  tick_cnt, mid_tgt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_err;
  logic        tick, mid, start_go;

  always_comb begin
    div_val = div_of(115200);
    case (baud_lat)
      3'd0: div_val = div_of(300);
      3'd1: div_val = div_of(1200);
      3'd2: div_val = div_of(4800);
      3'd3: div_val = div_of(9600);
      3'd4: div_val = div_of(19200);
      3'd5: div_val = div_of(38400);
      3'd6: div_val = div_of(57600);
      default: div_val = div_of(115200);
    endcase
  end

  // Start bit is sampled half a bit in; every later sample is one bit apart.
  assign tick    = (div_cnt == div_val - 32'd1);
  assign mid_tgt = (state == START) ? 4'd7 : 4'd15;
  assign mid     = tick && (tick_cnt == mid_tgt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    if (!Rx_EN) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (rx_prev && !rx_s2) begin state_n = START; start_go = 1'b1; end
        START:   if (mid) state_n = rx_s2 ? IDLE : DATA;
        DATA:    if (mid && bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  if (mid) state_n = STOP;
        STOP:    if (mid) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      baud_lat   <= 3'd0;
      div_cnt    <= 32'd0;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_err    <= 1'b0;
      Rx_DATA    <= 8'h00;
      Rx_VALID   <= 1'b0;
      Rx_PERROR  <= 1'b0;
      Rx_FERROR  <= 1'b0;
      buf_word   <= 32'h0;
      byte_count <= 3'd0;
    end else begin
      rx_s1    <= RxD;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      Rx_VALID <= 1'b0;
      if (start_go) baud_lat <= baud_select;
      // Counters are pinned to zero while idle so each frame starts in phase.
      if (state == IDLE) begin
        div_cnt  <= 32'd0;
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
      end else if (tick) begin
        div_cnt  <= 32'd0;
        tick_cnt <= mid ? 4'd0 : tick_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt + 32'd1;
      end
      if (Rx_EN && mid) begin
        case (state)
          START: if (!rx_s2) begin Rx_PERROR <= 1'b0; Rx_FERROR <= 1'b0; end
          DATA: begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_err <= (^shreg) ^ rx_s2;
          STOP: begin
            if (!par_err && rx_s2) begin
              Rx_DATA  <= shreg;
              Rx_VALID <= 1'b1;
              buf_word <= {buf_word[23:0], shreg};
              if (byte_count != 3'(BUF_BYTES)) byte_count <= byte_count + 3'd1;
            end else begin
              Rx_PERROR <= par_err;
              Rx_FERROR <= !rx_s2;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_capture.sv
// Scoreboard bench: good frames push expected outputs, a monitor pops on Rx_VALID.
module tb_uart_rx_frame_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  baud_select;
  logic        Rx_EN;
  logic        RxD;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID, Rx_PERROR, Rx_FERROR;
  logic [31:0] buf_word;
  logic [2:0]  byte_count;

  // 1.8432 MHz keeps frames short: divisors 384,96,24,12,6,3,2,1.
  uart_rx_frame_capture #(.CLK_HZ(1_843_200), .BUF_BYTES(4)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR),
    .buf_word(buf_word), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] bw;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   div_tab [8] = '{384, 96, 24, 12, 6, 3, 2, 1};
  logic valid_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [31:0] bw, input logic [2:0] c);
    exp_t e;
    e.data = d; e.bw = bw; e.cnt = c;
    sb.push_back(e);
  endtask

  // Drives the first nbits of {stop, parity, data LSB first, start}.
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stp,
                           input int nbits, input int clks);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      RxD = fr[i];
      repeat (clks) @(negedge clk);
    end
  endtask

  task automatic send_good(input logic [7:0] d, input int code);
    send_bits(d, ^d, 1'b1, 11, 16 * div_tab[code]);
    RxD = 1'b1;
    repeat (16 * div_tab[code]) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (Rx_VALID) begin
      chk("valid_pulse_width", {31'd0, valid_q}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%h expected=none", Rx_DATA);
      end else begin
        e = sb.pop_front();
        chk("rx_data", {24'd0, Rx_DATA}, {24'd0, e.data});
        chk("buf_word", buf_word, e.bw);
        chk("byte_count", {29'd0, byte_count}, {29'd0, e.cnt});
        chk("flags_on_valid", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
      end
    end
    valid_q = Rx_VALID;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Rx_EN = 1'b0; RxD = 1'b1; baud_select = 3'd7;
    repeat (4) @(negedge clk);
    chk("rst_data", {24'd0, Rx_DATA}, 32'h0);
    chk("rst_buf", buf_word, 32'h0);
    chk("rst_flags", {29'd0, Rx_VALID, Rx_PERROR, Rx_FERROR}, 32'h0);
    reset = 1'b0; Rx_EN = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_count", {29'd0, byte_count}, 32'h0);

    // Single byte at 115200.
    push(8'h55, 32'h0000_0055, 3'd1);
    send_good(8'h55, 7);
    chk("sb_empty_a", sb.size(), 32'd0);

    // Buffer fill and saturation at 9600; baud change mid-frame is ignored.
    baud_select = 3'd3;
    push(8'hFF, 32'h0000_55FF, 3'd2); send_good(8'hFF, 3);
    push(8'h15, 32'h0055_FF15, 3'd3); send_good(8'h15, 3);
    push(8'h55, 32'h55FF_1555, 3'd4); send_good(8'h55, 3);
    push(8'h55, 32'hFF15_5555, 3'd4); send_good(8'h55, 3);
    push(8'hA3, 32'h1555_55A3, 3'd4);
    fork
      send_good(8'hA3, 3);
      begin repeat (400) @(negedge clk); baud_select = 3'd7; end
    join
    chk("sb_empty_b", sb.size(), 32'd0);

    // Parity error, then a good byte clears the flag at its start bit.
    send_bits(8'h01, 1'b0, 1'b1, 11, 16);
    RxD = 1'b1; repeat (16) @(negedge clk);
    chk("perr_set", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd2);
    chk("perr_buf", buf_word, 32'h1555_55A3);
    chk("perr_data", {24'd0, Rx_DATA}, 32'hA3);
    push(8'h02, 32'h5555_A302, 3'd4);
    fork
      send_good(8'h02, 7);
      begin repeat (48) @(negedge clk); chk("perr_clear", {31'd0, Rx_PERROR}, 32'd0); end
    join

    // Framing error, then line held low must not start a frame.
    send_bits(8'h3C, 1'b0, 1'b0, 11, 16);
    RxD = 1'b0; repeat (32) @(negedge clk);
    RxD = 1'b1; repeat (48) @(negedge clk);
    chk("ferr_set", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd1);
    chk("ferr_data", {24'd0, Rx_DATA}, 32'h02);

    // Four-tick glitch is rejected without touching the flags.
    RxD = 1'b0; repeat (4) @(negedge clk);
    RxD = 1'b1; repeat (64) @(negedge clk);
    chk("glitch_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd1);
    chk("glitch_count", {29'd0, byte_count}, 32'd4);

    // Receiver disabled during data bit 4: frame dropped.
    send_bits(8'h99, 1'b0, 1'b1, 5, 16);
    RxD = 1'b1; repeat (8) @(negedge clk);
    Rx_EN = 1'b0; repeat (48) @(negedge clk);
    Rx_EN = 1'b1; repeat (32) @(negedge clk);
    chk("en_drop_buf", buf_word, 32'h5555_A302);
    chk("en_drop_count", {29'd0, byte_count}, 32'd4);
    chk("en_drop_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);

    // Reset during data of 0x7E, then a clean 0x7E.
    send_bits(8'h7E, 1'b0, 1'b1, 4, 16);
    reset = 1'b1; RxD = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_rst_buf", buf_word, 32'h0);
    chk("mid_rst_misc", {Rx_DATA, 5'd0, byte_count, 6'd0, Rx_PERROR, Rx_FERROR}, 32'h0);
    push(8'h7E, 32'h0000_007E, 3'd1);
    send_good(8'h7E, 7);
    repeat (16) @(negedge clk);
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
